// File: rtl/ivl_uvm_apb_responder.sv
// APB completer: DEPTH-word register file, CTRL.WAIT programmable wait states,
// pslverr on misaligned/unmapped addresses, completed-transfer and error counters.
module ivl_uvm_apb_responder #(
  parameter  int unsigned ADDR_W = 8,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned TXN_W  = 16,
  localparam int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [TXN_W-1:0]  txn_count,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = {{WIDX_W{1'b1}}, 2'b00};

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    r_wait;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [TXN_W-1:0]    r_txn_count;
  logic [ERR_W-1:0]    r_err_count;

  logic                w_setup;
  logic                w_done;
  logic                w_is_mem;
  logic                w_is_ctrl;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_wmask;

  // Address decode of the latched transfer
  assign w_is_mem  = (r_addr[1:0] == 2'b00) && (r_addr[ADDR_W-1:2] < WIDX_W'(DEPTH));
  assign w_is_ctrl = (r_addr == CTRL_ADDR);
  assign w_err     = !(w_is_mem || w_is_ctrl);
  assign w_idx     = r_addr[IDX_W+1:2];
  assign w_rdata   = w_is_ctrl ? DATA_W'(r_wait) : (w_is_mem ? r_mem[w_idx] : '0);
  assign w_wmask   = {{8{r_strb[3]}}, {8{r_strb[2]}}, {8{r_strb[1]}}, {8{r_strb[0]}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_setup     = 1'b0;
    w_done      = 1'b0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;
    case (r_state)
      IDLE: begin
        // psel with penable already high has no setup phase and is ignored
        if (psel && !penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = r_wait;
          w_setup     = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          w_state_nxt = IDLE;
        end else if (penable) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            pready      = 1'b1;
            pslverr     = w_err;
            prdata      = (r_write || w_err) ? '0 : w_rdata;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transfer latch, memory/CTRL commit and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait      <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_txn_count <= '0;
      r_err_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[IDX_W'(i)] <= '0;
      end
    end else begin
      if (w_setup) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
        r_strb  <= pstrb;
      end
      if (w_done) begin
        r_txn_count <= r_txn_count + TXN_W'(1);
        if (w_err && (r_err_count != '1)) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
        if (r_write && w_is_ctrl && r_strb[0]) begin
          r_wait <= r_wdata[CNT_W-1:0];
        end
        if (r_write && w_is_mem) begin
          r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (r_wdata & w_wmask);
        end
      end
    end
  end

  assign txn_count = r_txn_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ivl_uvm_apb_responder.sv
// Scoreboard bench for ivl_uvm_apb_responder: a reference model pushes expected
// read data / error / transfer length at drive time, popped when pready returns.
module tb_ivl_uvm_apb_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic        rd;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mem [16];
  logic [3:0]  m_wait;
  int          m_txn;
  int          m_err;

  ivl_uvm_apb_responder dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_wait = '0;
    m_txn  = 0;
    m_err  = 0;
  endfunction

  function automatic exp_t model_xfer(input stim_t s);
    exp_t e;
    logic is_mem;
    logic is_ctrl;
    is_mem   = (s.addr[1:0] == 2'b00) && (s.addr < 8'h40);
    is_ctrl  = (s.addr == 8'hFC);
    e.err    = !(is_mem || is_ctrl);
    e.rd     = !s.wr;
    e.cycles = 2 + int'(m_wait);
    e.rdata  = '0;
    if (!s.wr && is_ctrl) e.rdata = {28'h0, m_wait};
    else if (!s.wr && is_mem) e.rdata = m_mem[s.addr[5:2]];
    else if (s.wr && is_ctrl && s.strb[0]) m_wait = s.data[3:0];
    else if (s.wr && is_mem) begin
      for (int b = 0; b < 4; b++)
        if (s.strb[b]) m_mem[s.addr[5:2]][8*b +: 8] = s.data[8*b +: 8];
    end
    m_txn = (m_txn + 1) % 65536;
    if (e.err && m_err < 255) m_err++;
    return e;
  endfunction

  // Drives setup then access; returns the completion sample and the length in
  // cycles counted from the setup cycle (bounded at 40).
  task automatic apb_xfer(input stim_t s, output logic [31:0] rdata, output logic err,
                          output int cycles);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = s.wr; paddr = s.addr; pwdata = s.data; pstrb = s.strb;
    @(negedge clk);
    penable = 1'b1;
    #1;
    cycles = 2;
    while (pready !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    rdata = prdata;
    err   = pslverr;
    if (pready !== 1'b1) cycles = -1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pready, pslverr, prdata, txn_count, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h txn=%0d err=%0d, want all 0",
               pready, pslverr, prdata, txn_count, err_count);
    end
  endtask

  task automatic test_write_read();
    stim_t s [2];
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    s = '{'{1'b1, 8'h08, 32'hDEADBEEF, 4'hF}, '{1'b0, 8'h08, 32'h0, 4'h0}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model_xfer(s[i]));
      apb_xfer(s[i], rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL write_read[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
    checks++;
    if (txn_count !== 16'd2 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL write_read_counters: got txn=%0d err=%0d, want txn=2 err=0", txn_count, err_count);
    end
  endtask

  task automatic test_partial_strobe();
    stim_t s [2];
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    s = '{'{1'b1, 8'h00, 32'h11223344, 4'b0101}, '{1'b0, 8'h00, 32'h0, 4'h0}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model_xfer(s[i]));
      apb_xfer(s[i], rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL partial_strobe[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
  endtask

  task automatic test_wait_states();
    stim_t s [4];
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    s = '{'{1'b1, 8'hFC, 32'h5, 4'hF}, '{1'b0, 8'h04, 32'h0, 4'h0},
          '{1'b0, 8'hFC, 32'h0, 4'h0}, '{1'b1, 8'hFC, 32'hFFFF_FFF0, 4'h1}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model_xfer(s[i]));
      apb_xfer(s[i], rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL wait_states[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
  endtask

  task automatic test_errors();
    stim_t s [4];
    stim_t t;
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    s = '{'{1'b1, 8'h40, 32'hA5A5A5A5, 4'hF}, '{1'b1, 8'h02, 32'h5A5A5A5A, 4'hF},
          '{1'b0, 8'h08, 32'h0, 4'h0}, '{1'b0, 8'h00, 32'h0, 4'h0}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model_xfer(s[i]));
      apb_xfer(s[i], rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL errors[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
    checks++;
    if (err_count !== 8'(m_err)) begin
      errors++;
      $display("FAIL err_count_two: got %0d, want %0d", err_count, m_err);
    end
    for (int i = 0; i < 300; i++) begin
      t = (i % 2 == 0) ? stim_t'{1'b1, 8'h40, 32'(i), 4'hF} : stim_t'{1'b0, 8'h81, 32'h0, 4'h0};
      sb.push_back(model_xfer(t));
      apb_xfer(t, rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL err_burst[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
    checks++;
    if (err_count !== 8'hFF || txn_count !== 16'(m_txn)) begin
      errors++;
      $display("FAIL err_saturate: got err=%0d txn=%0d, want err=255 txn=%0d", err_count, txn_count, m_txn);
    end
  endtask

  task automatic test_abort_violation();
    stim_t s;
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    s = '{1'b1, 8'hFC, 32'h3, 4'hF};
    sb.push_back(model_xfer(s));
    apb_xfer(s, rd, er, cy);
    e = sb.pop_front();
    checks++;
    if (er !== e.err || cy != e.cycles) begin
      errors++;
      $display("FAIL set_wait3: got err=%b cycles=%0d, want err=%b cycles=%0d", er, cy, e.err, e.cycles);
    end
    // setup, one access cycle, then psel drops
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL abort_stall: got pready=%b, want 0", pready);
    end
    go_idle();
    go_idle();
    checks++;
    if (txn_count !== 16'(m_txn)) begin
      errors++;
      $display("FAIL abort_count: got txn=%0d, want %0d", txn_count, m_txn);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h12345678;
      #1;
      checks++;
      if (pready !== 1'b0) begin
        errors++;
        $display("FAIL violation[%0d]: got pready=%b, want 0", i, pready);
      end
    end
    go_idle();
    s = '{1'b0, 8'h10, 32'h0, 4'h0};
    sb.push_back(model_xfer(s));
    apb_xfer(s, rd, er, cy);
    e = sb.pop_front();
    checks++;
    if (er !== e.err || cy != e.cycles || rd !== e.rdata) begin
      errors++;
      $display("FAIL abort_readback: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
               rd, er, cy, e.rdata, e.err, e.cycles);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_access();
    stim_t s [2];
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hBADC0FFE; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    #1;
    checks++;
    if (txn_count !== 16'd0 || err_count !== 8'd0 || pready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got txn=%0d err=%0d pready=%b, want 0 0 0", txn_count, err_count, pready);
    end
    s = '{'{1'b0, 8'h0C, 32'h0, 4'h0}, '{1'b0, 8'hFC, 32'h0, 4'h0}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model_xfer(s[i]));
      apb_xfer(s[i], rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t e;
    logic [31:0] rd; logic er; int cy;
    for (int i = 0; i < 16; i++) begin
      s.wr   = (i < 8);
      s.addr = 8'((i % 8) * 4);
      s.data = $urandom;
      s.strb = 4'($urandom_range(1, 15));
      sb.push_back(model_xfer(s));
      apb_xfer(s, rd, er, cy);
      e = sb.pop_front();
      checks++;
      if (er !== e.err || cy != e.cycles || (e.rd && rd !== e.rdata)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got rdata=%h err=%b cycles=%0d, want rdata=%h err=%b cycles=%0d",
                 i, rd, er, cy, e.rdata, e.err, e.cycles);
      end
    end
    go_idle();
    checks++;
    if (txn_count !== 16'(m_txn) || err_count !== 8'(m_err)) begin
      errors++;
      $display("FAIL b2b_counters: got txn=%0d err=%0d, want txn=%0d err=%0d", txn_count, err_count, m_txn, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_wait_states();
    test_errors();
    test_abort_violation();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
